// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: single outstanding request, one-entry holding register, redirect/kill.
// Optional macro FETCH_CTRL_ALIGN_CHECK_EN rejects misaligned redirects and pulses misalign.
module fetch_ctrl #(
    parameter logic [31:0] START_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_pc,
    input  logic [31:0] new_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] pc,
    output logic        misalign
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc_n;
    logic        kill, kill_n;
    logic        capture;
    logic        bad_align;
    logic        redir;

`ifdef FETCH_CTRL_ALIGN_CHECK_EN
    assign bad_align = set_pc && (new_pc[1:0] != 2'b00);
`else
    assign bad_align = 1'b0;
`endif

    // A rejected (misaligned) redirect behaves exactly as if set_pc were low.
    assign redir     = set_pc && !bad_align;
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_REQ;
            pc       <= START_ADDR;
            kill     <= 1'b0;
            inst     <= '0;
            inst_pc  <= '0;
            misalign <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            kill     <= kill_n;
            misalign <= bad_align;
            if (capture) begin
                inst    <= imem_rdata;
                inst_pc <= pc;
            end
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        kill_n     = kill;
        capture    = 1'b0;
        imem_req   = 1'b0;
        inst_valid = 1'b0;

        case (state)
            S_REQ: begin
                imem_req = !redir;
                if (redir) begin
                    pc_n = new_pc;
                end else if (imem_gnt) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redir) begin
                    pc_n = new_pc;
                end
                // Data for a superseded request is dropped whether the redirect came earlier or now.
                if (imem_rvalid) begin
                    if (kill || redir) begin
                        kill_n  = 1'b0;
                        state_n = S_REQ;
                    end else begin
                        capture = 1'b1;
                        state_n = S_HOLD;
                    end
                end else if (redir) begin
                    kill_n = 1'b1;
                end
            end
            S_HOLD: begin
                inst_valid = !redir;
                if (redir) begin
                    pc_n    = new_pc;
                    state_n = S_REQ;
                end else if (inst_ready) begin
                    pc_n    = pc + 32'd4;
                    state_n = S_REQ;
                end
            end
            default: begin
                state_n = S_REQ;
            end
        endcase

        if (rst) begin
            imem_req   = 1'b0;
            inst_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl with START_ADDR = 0x80000000.
`timescale 1ns/1ps
module tb_fetch_ctrl;

    localparam logic [31:0] START = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        set_pc;
    logic [31:0] new_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] pc;
    logic        misalign;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.START_ADDR(START)) dut (
        .clk(clk), .rst(rst), .set_pc(set_pc), .new_pc(new_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .pc(pc), .misalign(misalign)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; set_pc = 1'b0; new_pc = '0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
        step(); step();
        #1;
        total++; if (pc !== START) $display("FAIL reset_pc got %h want %h", pc, START); else passed++;
        total++; if (imem_req !== 1'b0) $display("FAIL reset_req got %b want 0", imem_req); else passed++;
        total++; if (inst_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", inst_valid); else passed++;
        total++; if (inst !== 32'h0) $display("FAIL reset_inst got %h want 0", inst); else passed++;
        total++; if (inst_pc !== 32'h0) $display("FAIL reset_inst_pc got %h want 0", inst_pc); else passed++;
        total++; if (misalign !== 1'b0) $display("FAIL reset_misalign got %b want 0", misalign); else passed++;
        step();
    endtask

    task automatic test_fetch();
        rst = 1'b0; imem_gnt = 1'b1;
        #1;
        total++; if (imem_req !== 1'b1) $display("FAIL first_req got %b want 1", imem_req); else passed++;
        total++; if (imem_addr !== START) $display("FAIL first_addr got %h want %h", imem_addr, START); else passed++;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
        #1;
        total++; if (imem_req !== 1'b0) $display("FAIL wait_req got %b want 0", imem_req); else passed++;
        total++; if (inst_valid !== 1'b0) $display("FAIL wait_valid got %b want 0", inst_valid); else passed++;
        step();
        imem_rvalid = 1'b0; inst_ready = 1'b1;
        #1;
        total++; if (inst_valid !== 1'b1) $display("FAIL hold_valid got %b want 1", inst_valid); else passed++;
        total++; if (inst !== 32'h0000_0013) $display("FAIL hold_inst got %h want 00000013", inst); else passed++;
        total++; if (inst_pc !== START) $display("FAIL hold_inst_pc got %h want %h", inst_pc, START); else passed++;
        step();
        inst_ready = 1'b0;
        #1;
        total++; if (imem_addr !== 32'h8000_0004) $display("FAIL next_addr got %h want 80000004", imem_addr); else passed++;
        total++; if (imem_req !== 1'b1) $display("FAIL next_req got %b want 1", imem_req); else passed++;
    endtask

    task automatic test_stall();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0010_0093;
        step();
        imem_rvalid = 1'b0; inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (inst_valid !== 1'b1) $display("FAIL stall_valid[%0d] got %b want 1", i, inst_valid); else passed++;
            total++; if (inst !== 32'h0010_0093) $display("FAIL stall_inst[%0d] got %h want 00100093", i, inst); else passed++;
            total++; if (inst_pc !== 32'h8000_0004) $display("FAIL stall_inst_pc[%0d] got %h want 80000004", i, inst_pc); else passed++;
            total++; if (imem_req !== 1'b0) $display("FAIL stall_req[%0d] got %b want 0", i, imem_req); else passed++;
            total++; if (pc !== 32'h8000_0004) $display("FAIL stall_pc[%0d] got %h want 80000004", i, pc); else passed++;
            step();
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        #1;
        total++; if (pc !== 32'h8000_0008) $display("FAIL stall_release_pc got %h want 80000008", pc); else passed++;
    endtask

    task automatic test_kill_wait();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; set_pc = 1'b1; new_pc = 32'h100;
        #1;
        total++; if (imem_req !== 1'b0) $display("FAIL kill_req got %b want 0", imem_req); else passed++;
        step();
        set_pc = 1'b0;
        #1;
        total++; if (pc !== 32'h100) $display("FAIL kill_pc got %h want 00000100", pc); else passed++;
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        total++; if (inst_valid !== 1'b0) $display("FAIL kill_valid_rv got %b want 0", inst_valid); else passed++;
        step();
        imem_rvalid = 1'b0;
        #1;
        total++; if (inst_valid !== 1'b0) $display("FAIL kill_valid_after got %b want 0", inst_valid); else passed++;
        total++; if (inst !== 32'h0010_0093) $display("FAIL kill_inst got %h want 00100093", inst); else passed++;
        total++; if (imem_req !== 1'b1) $display("FAIL kill_next_req got %b want 1", imem_req); else passed++;
        total++; if (imem_addr !== 32'h100) $display("FAIL kill_next_addr got %h want 00000100", imem_addr); else passed++;
    endtask

    task automatic test_redirect_with_rvalid();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; set_pc = 1'b1; new_pc = 32'h300; imem_rvalid = 1'b1; imem_rdata = 32'h55;
        #1;
        total++; if (inst_valid !== 1'b0) $display("FAIL rvredir_valid got %b want 0", inst_valid); else passed++;
        step();
        set_pc = 1'b0; imem_rvalid = 1'b0;
        #1;
        total++; if (imem_addr !== 32'h300) $display("FAIL rvredir_addr got %h want 00000300", imem_addr); else passed++;
        total++; if (imem_req !== 1'b1) $display("FAIL rvredir_req got %b want 1", imem_req); else passed++;
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h77;
        step();
        imem_rvalid = 1'b0;
        #1;
        total++; if (inst_valid !== 1'b1) $display("FAIL rvredir_next_valid got %b want 1", inst_valid); else passed++;
        total++; if (inst !== 32'h77) $display("FAIL rvredir_next_inst got %h want 00000077", inst); else passed++;
        total++; if (inst_pc !== 32'h300) $display("FAIL rvredir_next_pc got %h want 00000300", inst_pc); else passed++;
    endtask

    task automatic test_redirect_hold();
        set_pc = 1'b1; new_pc = 32'h200; inst_ready = 1'b1;
        #1;
        total++; if (inst_valid !== 1'b0) $display("FAIL holdredir_valid got %b want 0", inst_valid); else passed++;
        step();
        set_pc = 1'b0; inst_ready = 1'b0;
        #1;
        total++; if (pc !== 32'h200) $display("FAIL holdredir_pc got %h want 00000200", pc); else passed++;
        total++; if (imem_req !== 1'b1) $display("FAIL holdredir_req got %b want 1", imem_req); else passed++;
        total++; if (imem_addr !== 32'h200) $display("FAIL holdredir_addr got %h want 00000200", imem_addr); else passed++;
    endtask

    task automatic test_wrap();
        set_pc = 1'b1; new_pc = 32'hFFFF_FFFC;
        step();
        set_pc = 1'b0; imem_gnt = 1'b1;
        #1;
        total++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr got %h want fffffffc", imem_addr); else passed++;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h33;
        step();
        imem_rvalid = 1'b0; inst_ready = 1'b1;
        #1;
        total++; if (inst_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_inst_pc got %h want fffffffc", inst_pc); else passed++;
        step();
        inst_ready = 1'b0;
        #1;
        total++; if (imem_addr !== 32'h0) $display("FAIL wrap_next_addr got %h want 00000000", imem_addr); else passed++;
    endtask

    task automatic test_misalign();
        logic        exp_req;
        logic [31:0] exp_pc;
        logic        exp_mis;
`ifdef FETCH_CTRL_ALIGN_CHECK_EN
        exp_req = 1'b1; exp_pc = 32'h0;   exp_mis = 1'b1;
`else
        exp_req = 1'b0; exp_pc = 32'h102; exp_mis = 1'b0;
`endif
        set_pc = 1'b1; new_pc = 32'h102; imem_gnt = 1'b0;
        #1;
        total++; if (imem_req !== exp_req) $display("FAIL mis_req got %b want %b", imem_req, exp_req); else passed++;
        step();
        set_pc = 1'b0;
        #1;
        total++; if (pc !== exp_pc) $display("FAIL mis_pc got %h want %h", pc, exp_pc); else passed++;
        total++; if (misalign !== exp_mis) $display("FAIL mis_pulse got %b want %b", misalign, exp_mis); else passed++;
        step();
        #1;
        total++; if (misalign !== 1'b0) $display("FAIL mis_clear got %b want 0", misalign); else passed++;
    endtask

    task automatic test_reset_midtx();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; rst = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0) $display("FAIL midrst_req got %b want 0", imem_req); else passed++;
        step();
        rst = 1'b0;
        #1;
        total++; if (imem_req !== 1'b1) $display("FAIL midrst_after_req got %b want 1", imem_req); else passed++;
        total++; if (imem_addr !== START) $display("FAIL midrst_addr got %h want %h", imem_addr, START); else passed++;
        total++; if (inst !== 32'h0) $display("FAIL midrst_inst got %h want 0", inst); else passed++;
        total++; if (inst_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", inst_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_kill_wait();
        test_redirect_with_rvalid();
        test_redirect_hold();
        test_wrap();
        test_misalign();
        test_reset_midtx();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: START_ADDR, default 0, the PC value loaded on reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: set_pc  input  1  redirect request from execute (branch/jump).
REQ-005 Port: new_pc  input  32  redirect target, sampled when set_pc=1.
REQ-006 Port: imem_req  output  1  instruction memory request valid.
REQ-007 Port: imem_addr  output  32  request address; equals pc.
REQ-008 Port: imem_gnt  input  1  memory accepts request when imem_req=1.
REQ-009 Port: imem_rvalid  input  1  read data valid, one cycle per accepted request.
REQ-010 Port: imem_rdata  input  32  returned instruction word.
REQ-011 Port: inst_valid  output  1  instruction available to decode.
REQ-012 Port: inst_ready  input  1  decode accepts instruction.
REQ-013 Port: inst  output  32  held instruction word.
REQ-014 Port: inst_pc  output  32  address of held instruction.
REQ-015 Port: pc  output  32  current fetch PC register.
REQ-016 Port: misalign  output  1  one-cycle pulse on rejected misaligned redirect.

Function
REQ-017 FSM states SHALL be S_REQ, S_WAIT, S_HOLD; at most one memory request outstanding.
REQ-018 S_REQ: imem_req = !set_pc; on imem_req & imem_gnt -> S_WAIT; otherwise stay.
REQ-019 S_WAIT: on imem_rvalid with kill=0 -> latch inst<=imem_rdata, inst_pc<=pc, -> S_HOLD.
REQ-020 S_WAIT: on imem_rvalid with kill=1 -> discard data, clear kill, -> S_REQ.
REQ-021 S_HOLD: inst_valid = !set_pc; on inst_valid & inst_ready -> pc<=pc+4 (mod 2^32, wraps 0xFFFFFFFC->0), -> S_REQ.
REQ-022 inst_valid SHALL be 0 in S_REQ and S_WAIT; inst/inst_pc stable while inst_valid=1.
REQ-023 set_pc=1 in any state SHALL load pc<=new_pc at the next edge, overriding pc+4.
REQ-024 set_pc in S_REQ: no request issued that cycle; stay S_REQ.
REQ-025 set_pc in S_WAIT without imem_rvalid: set kill=1, stay S_WAIT.
REQ-026 set_pc in S_WAIT with imem_rvalid same cycle: discard data, -> S_REQ, kill stays 0.
REQ-027 set_pc in S_HOLD: held instruction dropped (not handed off even if inst_ready=1), -> S_REQ.
REQ-028 Best-case throughput: one instruction per 3 cycles (gnt immediate, rvalid next cycle, ready immediate).
REQ-029 First imem_req SHALL assert in the first cycle after rst deasserts, with imem_addr=START_ADDR.

Reset
REQ-030 rst=1 SHALL set state=S_REQ, pc=START_ADDR, kill=0, inst=0, inst_pc=0, misalign=0; outputs imem_req=0 and inst_valid=0 while rst=1.
REQ-031 Reset mid-transaction SHALL abandon any outstanding request; instruction memory shares rst and returns no stale rvalid.

Configuration
REQ-032 Macro FETCH_CTRL_ALIGN_CHECK_EN defined: set_pc with new_pc[1:0]!=0 SHALL be ignored entirely (pc, state, kill unchanged, request/handoff proceed normally) and misalign SHALL pulse 1 for the following cycle.
REQ-033 Macro FETCH_CTRL_ALIGN_CHECK_EN undefined: new_pc accepted verbatim regardless of alignment; misalign tied 0.

Verification
REQ-034 Reset release, START_ADDR=0x80000000, gnt=1, rvalid next cycle, rdata=0x00000013, ready=1 -> imem_addr=0x80000000, inst_valid on cycle 3 with inst=0x13, inst_pc=0x80000000, next imem_addr=0x80000004.
REQ-035 Hold inst_ready=0 for 5 cycles in S_HOLD -> inst_valid stays 1, inst/inst_pc unchanged, imem_req=0, pc unchanged.
REQ-036 set_pc=1, new_pc=0x100 while in S_WAIT, rvalid 2 cycles later with rdata=0xDEADBEEF -> 0xDEADBEEF never presented; next imem_addr=0x100.
REQ-037 set_pc=1, new_pc=0x200 in S_HOLD with inst_ready=1 -> inst_valid=0 that cycle, pc=0x200, next request addr=0x200.
REQ-038 pc=0xFFFFFFFC, instruction handed off -> next imem_addr=0x00000000.
REQ-039 With FETCH_CTRL_ALIGN_CHECK_EN: set_pc=1, new_pc=0x102 -> misalign=1 for one cycle, pc unchanged; without macro -> pc=0x102, misalign=0.
